// File: rtl/decod_7seg2_hexa_scan.sv
// ============================================================================
// Module   : decod_7seg2_hexa_scan
// Brief    : Reads a multiplexed active-low 7-segment bus and recovers the hex
//            value shown on each digit. Define HEX_AF_EN to also decode A-F.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decod_7seg2_hexa_scan #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_n,
  input  logic [NDIG-1:0]     dig_n,
  output logic [4*NDIG-1:0]   hex_out,
  output logic [NDIG-1:0]     dig_valid,
  output logic                new_digit,
  output logic [2:0]          new_idx,
  output logic                err,
  output logic [6:0]          err_pattern
);

  localparam int             CW      = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [6:0]     BLANK   = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPT, HOLD} state_t;

  state_t            state, state_nx;
  logic [6:0]        smp_seg, prv_seg, held_seg;
  logic [NDIG-1:0]   smp_dig, prv_dig, held_dig;
  logic [CW-1:0]     cnt;
  logic [2:0]        idx;
  logic [4:0]        dec;
  logic              changed, onehot, capture, fresh;

  // Returns {hit, value} for an active-high abcdefg pattern.
  function automatic logic [4:0] decode(input logic [6:0] seg_ah);
    case (seg_ah)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011: decode = 5'h19;
`ifdef HEX_AF_EN
      7'b1110111: decode = 5'h1A;
      7'b0011111: decode = 5'h1B;
      7'b1001110: decode = 5'h1C;
      7'b0111101: decode = 5'h1D;
      7'b1001111: decode = 5'h1E;
      7'b1000111: decode = 5'h1F;
`endif
      default:    decode = 5'h00;
    endcase
  endfunction

  assign changed = (smp_seg != prv_seg) || (smp_dig != prv_dig);
  assign onehot  = $onehot(~smp_dig);
  assign dec     = decode(~smp_seg);
  assign capture = (state == SETTLE) && onehot && !changed && (cnt == CNT_MAX);
  // A pattern identical to the last captured one (e.g. after a short glitch) is not re-reported.
  assign fresh   = capture && !((smp_seg == held_seg) && (smp_dig == held_dig));

  always_comb begin
    idx = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (!smp_dig[k]) idx = 3'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (onehot) state_nx = SETTLE;
      SETTLE: begin
        if (!onehot)      state_nx = IDLE;
        else if (capture) state_nx = fresh ? CAPT : HOLD;
      end
      // CAPT and HOLD both leave as soon as the bus moves, so no change is lost.
      CAPT, HOLD: begin
        if (!onehot)      state_nx = IDLE;
        else if (changed) state_nx = SETTLE;
        else              state_nx = HOLD;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_seg     <= BLANK;
      smp_dig     <= '1;
      prv_seg     <= BLANK;
      prv_dig     <= '1;
      held_seg    <= BLANK;
      held_dig    <= '1;
      cnt         <= '0;
      hex_out     <= '0;
      dig_valid   <= '0;
      new_digit   <= 1'b0;
      new_idx     <= '0;
      err         <= 1'b0;
      err_pattern <= BLANK;
    end else begin
      smp_seg   <= seg_n;
      smp_dig   <= dig_n;
      prv_seg   <= smp_seg;
      prv_dig   <= smp_dig;
      new_digit <= 1'b0;
      err       <= 1'b0;
      if (changed || !onehot)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      if (fresh) begin
        held_seg <= smp_seg;
        held_dig <= smp_dig;
        for (int k = 0; k < NDIG; k++) begin
          if (idx == 3'(k)) begin
            if (smp_seg == BLANK) begin
              dig_valid[k] <= 1'b0;
            end else if (dec[4]) begin
              hex_out[4*k +: 4] <= dec[3:0];
              dig_valid[k]      <= 1'b1;
            end else begin
              dig_valid[k]      <= 1'b0;
            end
          end
        end
        if (smp_seg != BLANK) begin
          new_idx <= idx;
          if (dec[4]) begin
            new_digit <= 1'b1;
          end else begin
            err         <= 1'b1;
            err_pattern <= smp_seg;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decod_7seg2_hexa_scan.sv
// Bench for decod_7seg2_hexa_scan: directed display scenarios plus random bus holds,
// checked every cycle against a hold-level model of the display reader.
`default_nettype none

module tb_decod_7seg2_hexa_scan;

  localparam int NDIG = 4;
  localparam int S    = 4;
`ifdef HEX_AF_EN
  localparam int NDEC = 16;
`else
  localparam int NDEC = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic [15:0] hex_out;
  logic [3:0]  dig_valid;
  logic        new_digit;
  logic [2:0]  new_idx;
  logic        err;
  logic [6:0]  err_pattern;

  decod_7seg2_hexa_scan #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_n(dig_n),
    .hex_out(hex_out), .dig_valid(dig_valid), .new_digit(new_digit),
    .new_idx(new_idx), .err(err), .err_pattern(err_pattern)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [6:0] seg; logic [3:0] dig; } hold_t;

  // Active-high abcdefg patterns for 0..F
  logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int checks = 0, failures = 0;
  int cyc = 0, n_nd = 0, n_err = 0, last_nd_cyc = -1;
  hold_t sched [int];
  hold_t last_key, prev_in;
  logic [15:0] m_hex;
  logic [3:0]  m_valid;
  logic [2:0]  m_idx;
  logic [6:0]  m_errpat;
  logic        m_nd, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int lookup(input logic [6:0] ah);
    for (int i = 0; i < NDEC; i++) if (tbl[i] == ah) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_hex = '0; m_valid = '0; m_idx = '0; m_errpat = 7'h7F; m_nd = 0; m_err = 0;
    last_key = '{7'h7F, 4'hF};
    sched.delete();
  endtask

  task automatic model_apply(input hold_t h);
    int k, v;
    k = 0;
    for (int i = 0; i < NDIG; i++) if (!h.dig[i]) k = i;
    if (h.seg == 7'h7F) begin
      m_valid[k] = 1'b0;
    end else begin
      v = lookup(~h.seg);
      if (v >= 0) begin
        m_hex[4*k +: 4] = 4'(v); m_valid[k] = 1'b1; m_nd = 1'b1; m_idx = 3'(k);
      end else begin
        m_err = 1'b1; m_errpat = h.seg; m_idx = 3'(k); m_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    m_nd = 0; m_err = 0;
    if (sched.exists(cyc)) begin
      model_apply(sched[cyc]);
      sched.delete(cyc);
    end
    if (new_digit === 1'b1) begin n_nd++; last_nd_cyc = cyc; end
    if (err === 1'b1) n_err++;
    check("new_digit", 32'(new_digit), 32'(m_nd));
    check("err", 32'(err), 32'(m_err));
    check("hex_out", 32'(hex_out), 32'(m_hex));
    check("dig_valid", 32'(dig_valid), 32'(m_valid));
    check("new_idx", 32'(new_idx), 32'(m_idx));
    check("err_pattern", 32'(err_pattern), 32'(m_errpat));
  endtask

  // Drive one bus value for len clocks; a one-hot value held S+1 samples is captured S+2 clocks in.
  task automatic hold(input logic [6:0] seg, input logic [3:0] dig, input int len);
    hold_t h;
    h = '{seg, dig};
    seg_n = seg; dig_n = dig; prev_in = h;
    if ($onehot(~dig) && len >= S + 1) begin
      if (h != last_key) sched[cyc + S + 2] = h;
      last_key = h;
    end
    repeat (len) step();
  endtask

  function automatic logic [3:0] sel(input int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << k);
  endfunction

  int n0, e0, c0;
  logic [3:0] v0;
  logic [6:0] rs;
  logic [3:0] rd;
  int r, len;

  initial begin
    rst_n = 1'b0; seg_n = 7'h7F; dig_n = 4'hF; prev_in = '{7'h7F, 4'hF};
    model_reset();
    repeat (3) step();
    check("rst_errpat", 32'(err_pattern), 32'h7F);
    check("rst_valid", 32'(dig_valid), 32'h0);
    rst_n = 1'b1;
    step();

    // First capture latency on digit 0 showing "0"
    c0 = cyc;
    hold(~7'b1111110, sel(0), 8);
    check("lat_cycle", 32'(last_nd_cyc - c0), 32'(S + 2));
    check("lat_idx", 32'(new_idx), 32'd0);
    check("lat_valid", 32'(dig_valid), 32'b0001);
    check("lat_hex", 32'(hex_out[3:0]), 32'd0);

    // Two scan passes of 3,7,9,2
    for (int p = 0; p < 2; p++) begin
      n0 = n_nd;
      hold(~7'b1111001, sel(0), 10);
      hold(~7'b1110000, sel(1), 10);
      hold(~7'b1111011, sel(2), 10);
      hold(~7'b1101101, sel(3), 10);
      check("scan_pulses", 32'(n_nd - n0), 32'd4);
      check("scan_hex", 32'(hex_out), 32'h2973);
      check("scan_valid", 32'(dig_valid), 32'hF);
    end

    // Short glitch inside a stable 5 on digit 2
    hold(~7'b1011011, sel(2), 10);
    n0 = n_nd; e0 = n_err;
    hold(~7'b0110000, sel(2), 2);
    hold(~7'b1011011, sel(2), 10);
    check("glitch_pulses", 32'(n_nd - n0 + n_err - e0), 32'd0);
    check("glitch_hex", 32'(hex_out[11:8]), 32'd5);

    // Letter A on digit 1
    n0 = n_nd; e0 = n_err;
    hold(~7'b1110111, sel(1), 10);
`ifdef HEX_AF_EN
    check("A_pulse", 32'(n_nd - n0), 32'd1);
    check("A_hex", 32'(hex_out[7:4]), 32'hA);
`else
    check("A_err", 32'(n_err - e0), 32'd1);
    check("A_errpat", 32'(err_pattern), 32'b0001000);
    check("A_valid1", 32'(dig_valid[1]), 32'd0);
`endif

    // Two selects active, then a blank on valid digit 0
    n0 = n_nd; e0 = n_err; v0 = dig_valid;
    hold(~7'b0110000, 4'b0011, 10);
    hold(7'h7F, sel(0), 10);
    check("blank_pulses", 32'(n_nd - n0 + n_err - e0), 32'd0);
    check("blank_valid", 32'(dig_valid), 32'(v0 & 4'b1110));

    // Reset asserted while a new digit is settling
    hold(~7'b0110011, sel(3), 3);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_hex", 32'(hex_out), 32'h0);
    check("mid_rst_valid", 32'(dig_valid), 32'h0);
    check("mid_rst_errpat", 32'(err_pattern), 32'h7F);
    check("mid_rst_pulse", 32'({new_digit, err}), 32'h0);
    seg_n = 7'h7F; dig_n = 4'hF; prev_in = '{7'h7F, 4'hF};
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Random bus activity
    for (int t = 0; t < 300; t++) begin
      do begin
        if ($urandom_range(0, 9) < 8) rd = sel($urandom_range(0, 3));
        else                          rd = 4'($urandom_range(0, 15));
        r = $urandom_range(0, 9);
        if (r < 5)      rs = ~tbl[$urandom_range(0, 15)];
        else if (r < 7) rs = 7'h7F;
        else            rs = 7'($urandom);
      end while (hold_t'{rs, rd} == prev_in);
      len = ($urandom_range(0, 9) < 3) ? $urandom_range(1, S) : $urandom_range(S + 1, 12);
      hold(rs, rd, len);
    end
    hold(7'h7F, 4'hF, S + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
